// File: rtl/fcr.sv
// FCR command controller: pops one command word, dispatches it to the PHF or TAP
// target, and pushes exactly one response word back for every command.

`ifndef N_TAP_CTL_SIZE
`define N_TAP_CTL_SIZE 8
`endif
`ifndef C_TARGET_PHF
`define C_TARGET_PHF 8'h01
`endif
`ifndef C_TARGET_TAP
`define C_TARGET_TAP 8'h02
`endif
`ifndef C_PHF_CLEAR
`define C_PHF_CLEAR 8'h01
`endif
`ifndef C_PHF_GET_STATUS
`define C_PHF_GET_STATUS 8'h02
`endif
`ifndef C_TAP_SET
`define C_TAP_SET 8'h01
`endif

module fcr #(
  parameter int         N_TAP_CTL_SIZE   = `N_TAP_CTL_SIZE,
  parameter logic [7:0] C_TARGET_PHF     = `C_TARGET_PHF,
  parameter logic [7:0] C_TARGET_TAP     = `C_TARGET_TAP,
  parameter logic [7:0] C_PHF_CLEAR      = `C_PHF_CLEAR,
  parameter logic [7:0] C_PHF_GET_STATUS = `C_PHF_GET_STATUS,
  parameter logic [7:0] C_TAP_SET        = `C_TAP_SET
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               cmd_data,
  input  logic                      cmd_waitreq,
  output logic                      cmd_rdreq,
  output logic [31:0]               rsp_data,
  output logic                      rsp_wrreq,
  input  logic                      rsp_waitreq,
  output logic [N_TAP_CTL_SIZE-1:0] tap_ctl,
  input  logic                      phf_clear_busy,
  input  logic                      phf_status,
  output logic                      phf_rsp_rdy,
  output logic                      phf_clear_req
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_EXEC, S_CLR_REQ, S_CLR_BUSY, S_RESP
  } state_t;

  localparam logic [15:0] RES_OK          = 16'h0000;
  localparam logic [15:0] RES_BAD_OPCODE  = 16'hFFFF;
  localparam logic [15:0] RES_BAD_TARGET  = 16'hFFFE;
  localparam logic [15:0] RES_CLR_TIMEOUT = 16'hFFFD;

  state_t                    state_q;
  logic [31:0]               cmd_q;
  logic [7:0]                clr_cnt_q;
  logic                      cmd_rdreq_q;
  logic [31:0]               rsp_data_q;
  logic                      rsp_wrreq_q;
  logic [N_TAP_CTL_SIZE-1:0] tap_ctl_q;
  logic                      phf_rsp_rdy_q;
  logic                      phf_clear_req_q;

  logic [7:0]  cmd_target;
  logic [7:0]  cmd_opcode;
  logic [15:0] exec_result_d;
  logic        exec_clear_d;
  logic        exec_tap_d;

  assign cmd_target = cmd_q[31:24];
  assign cmd_opcode = cmd_q[23:16];

  // Decode of the latched command word, consumed only in S_EXEC.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    exec_result_d = RES_BAD_TARGET;
    exec_clear_d  = 1'b0;
    exec_tap_d    = 1'b0;
    if (cmd_target == C_TARGET_PHF) begin
      if (cmd_opcode == C_PHF_CLEAR) begin
        exec_clear_d  = 1'b1;
        exec_result_d = RES_OK;
      end else if (cmd_opcode == C_PHF_GET_STATUS) begin
        exec_result_d = {15'b0, phf_status};
      end else begin
        exec_result_d = RES_BAD_OPCODE;
      end
    end else if (cmd_target == C_TARGET_TAP) begin
      if (cmd_opcode == C_TAP_SET) begin
        exec_tap_d    = 1'b1;
        exec_result_d = RES_OK;
      end else begin
        exec_result_d = RES_BAD_OPCODE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cmd_q           <= '0;
      clr_cnt_q       <= '0;
      cmd_rdreq_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_wrreq_q     <= 1'b0;
      tap_ctl_q       <= '0;
      phf_rsp_rdy_q   <= 1'b0;
      phf_clear_req_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!cmd_waitreq) begin
            cmd_rdreq_q <= 1'b1;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          cmd_rdreq_q <= 1'b0;
          state_q     <= S_LATCH;
        end
        // FIFO data appears one cycle after the read strobe.
        S_LATCH: begin
          cmd_q   <= cmd_data;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          clr_cnt_q <= '0;
          if (exec_clear_d) begin
            phf_clear_req_q <= 1'b1;
            state_q         <= S_CLR_REQ;
          end else begin
            if (exec_tap_d) begin
              tap_ctl_q <= cmd_q[N_TAP_CTL_SIZE-1:0];
            end
            rsp_data_q <= {cmd_q[31:16], exec_result_d};
            state_q    <= S_RESP;
          end
        end
        // The timeout counter spans both clear states; expiry wins over handshakes.
        S_CLR_REQ: begin
          if (clr_cnt_q == 8'hFF) begin
            phf_clear_req_q <= 1'b0;
            rsp_data_q      <= {cmd_q[31:16], RES_CLR_TIMEOUT};
            state_q         <= S_RESP;
          end else begin
            clr_cnt_q <= clr_cnt_q + 8'd1;
            if (phf_clear_busy) begin
              phf_clear_req_q <= 1'b0;
              state_q         <= S_CLR_BUSY;
            end
          end
        end
        S_CLR_BUSY: begin
          if (clr_cnt_q == 8'hFF) begin
            rsp_data_q <= {cmd_q[31:16], RES_CLR_TIMEOUT};
            state_q    <= S_RESP;
          end else if (!phf_clear_busy) begin
            rsp_data_q <= {cmd_q[31:16], RES_OK};
            state_q    <= S_RESP;
          end else begin
            clr_cnt_q <= clr_cnt_q + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_wrreq_q) begin
            rsp_wrreq_q   <= 1'b0;
            phf_rsp_rdy_q <= 1'b0;
            state_q       <= S_IDLE;
          end else if (!rsp_waitreq) begin
            rsp_wrreq_q   <= 1'b1;
            phf_rsp_rdy_q <= (cmd_target == C_TARGET_PHF);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_rdreq     = cmd_rdreq_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_wrreq     = rsp_wrreq_q;
  assign tap_ctl       = tap_ctl_q;
  assign phf_rsp_rdy   = phf_rsp_rdy_q;
  assign phf_clear_req = phf_clear_req_q;

endmodule

// File: tb/tb_fcr.sv
// Directed bench for fcr: each scenario issues one command and checks the
// handshakes and the response word against hand-computed constants.

module tb_fcr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        cmd_waitreq = 1'b1;
  logic        cmd_rdreq;
  logic [31:0] rsp_data;
  logic        rsp_wrreq;
  logic        rsp_waitreq = 1'b0;
  logic [7:0]  tap_ctl;
  logic        phf_clear_busy = 1'b0;
  logic        phf_status = 1'b0;
  logic        phf_rsp_rdy;
  logic        phf_clear_req;

  int n_checks = 0;
  int n_errors = 0;

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          clr_cnt = 0;
  int          phf_cnt = 0;
  logic [31:0] last_rsp = '0;
  logic        last_phf = 1'b0;

  fcr dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_data       (cmd_data),
    .cmd_waitreq    (cmd_waitreq),
    .cmd_rdreq      (cmd_rdreq),
    .rsp_data       (rsp_data),
    .rsp_wrreq      (rsp_wrreq),
    .rsp_waitreq    (rsp_waitreq),
    .tap_ctl        (tap_ctl),
    .phf_clear_busy (phf_clear_busy),
    .phf_status     (phf_status),
    .phf_rsp_rdy    (phf_rsp_rdy),
    .phf_clear_req  (phf_clear_req)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rsp_wrreq) begin
      wr_cnt++;
      last_rsp = rsp_data;
      last_phf = phf_rsp_rdy;
    end
    if (cmd_rdreq)     rd_cnt++;
    if (phf_clear_req) clr_cnt++;
    if (phf_rsp_rdy)   phf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] word);
    tick();
    cmd_data    = word;
    cmd_waitreq = 1'b0;
    tick();
    cmd_waitreq = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int  start = wr_cnt;
    bit  got   = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (wr_cnt != start) got = 1'b1;
    end
    check({tag, "_wait"}, 32'(got), 32'd1);
  endtask

  task automatic wait_clear_req(input string tag, input int budget, output int cycles);
    bit got = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      cycles++;
      if (phf_clear_req) got = 1'b1;
    end
    check({tag, "_clr_req_seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdreq"},     32'(cmd_rdreq),     32'd0);
    check({tag, "_rsp_wrreq"},     32'(rsp_wrreq),     32'd0);
    check({tag, "_rsp_data"},      rsp_data,           32'd0);
    check({tag, "_tap_ctl"},       32'(tap_ctl),       32'd0);
    check({tag, "_phf_clear_req"}, 32'(phf_clear_req), 32'd0);
    check({tag, "_phf_rsp_rdy"},   32'(phf_rsp_rdy),   32'd0);
  endtask

  // Issues a command that needs no clear handshake and checks its single response.
  task automatic run_simple(input string tag, input logic [31:0] word,
                            input logic [31:0] exp_rsp, input int exp_phf);
    int wr0  = wr_cnt;
    int rd0  = rd_cnt;
    int ph0  = phf_cnt;
    int clr0 = clr_cnt;
    issue(word);
    wait_rsp(tag, 20);
    repeat (4) tick();
    check({tag, "_rsp"},       last_rsp,            exp_rsp);
    check({tag, "_writes"},    32'(wr_cnt - wr0),   32'd1);
    check({tag, "_reads"},     32'(rd_cnt - rd0),   32'd1);
    check({tag, "_phf_rdy"},   32'(phf_cnt - ph0),  32'(exp_phf));
    check({tag, "_no_clear"},  32'(clr_cnt - clr0), 32'd0);
  endtask

  initial begin
    int lat;
    int wr0;
    int rd0;
    int ph0;
    int clr0;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // PHF clear with a normal busy handshake
    wr0 = wr_cnt; rd0 = rd_cnt; ph0 = phf_cnt;
    issue(32'h0101_0001);
    wait_clear_req("clear", 10, lat);
    check("clear_latency_ok", 32'(lat <= 3), 32'd1);
    phf_clear_busy = 1'b1;
    tick();
    check("clear_req_dropped", 32'(phf_clear_req), 32'd0);
    repeat (5) tick();
    phf_clear_busy = 1'b0;
    wait_rsp("clear", 10);
    repeat (4) tick();
    check("clear_rsp",     last_rsp,           32'h0101_0000);
    check("clear_phf_rdy", 32'(last_phf),      32'd1);
    check("clear_writes",  32'(wr_cnt - wr0),  32'd1);
    check("clear_reads",   32'(rd_cnt - rd0),  32'd1);
    check("clear_phf_cnt", 32'(phf_cnt - ph0), 32'd1);

    // Decode of the remaining command classes
    run_simple("bad_phf_op", 32'h01AA_0001, 32'h01AA_FFFF, 1);
    phf_status = 1'b1;
    run_simple("status_1",   32'h0102_0001, 32'h0102_0001, 1);
    phf_status = 1'b0;
    run_simple("status_0",   32'h0102_0001, 32'h0102_0000, 1);
    run_simple("tap_set",    32'h0201_00A5, 32'h0201_0000, 0);
    check("tap_ctl_a5", 32'(tap_ctl), 32'h0000_00A5);
    run_simple("tap_bad_op", 32'h0202_0033, 32'h0202_FFFF, 0);
    check("tap_ctl_kept", 32'(tap_ctl), 32'h0000_00A5);
    run_simple("bad_target", 32'h0301_1234, 32'h0301_FFFE, 0);

    // Response backpressure
    phf_status  = 1'b1;
    rsp_waitreq = 1'b1;
    wr0 = wr_cnt;
    issue(32'h0102_0000);
    repeat (10) tick();
    check("bp_no_write",    32'(wr_cnt - wr0), 32'd0);
    check("bp_rsp_held",    rsp_data,          32'h0102_0001);
    check("bp_wrreq_low",   32'(rsp_wrreq),    32'd0);
    rsp_waitreq = 1'b0;
    wait_rsp("bp", 10);
    repeat (4) tick();
    check("bp_writes", 32'(wr_cnt - wr0), 32'd1);
    check("bp_rsp",    last_rsp,          32'h0102_0001);
    phf_status = 1'b0;

    // Clear timeout: busy never raised, request held for 256 cycles
    wr0 = wr_cnt; clr0 = clr_cnt;
    issue(32'h0101_0001);
    wait_rsp("timeout", 300);
    repeat (4) tick();
    check("timeout_rsp",      last_rsp,            32'h0101_FFFD);
    check("timeout_req_len",  32'(clr_cnt - clr0), 32'd256);
    check("timeout_req_low",  32'(phf_clear_req),  32'd0);
    check("timeout_writes",   32'(wr_cnt - wr0),   32'd1);

    // Busy already high when the clear request starts
    phf_clear_busy = 1'b1;
    wr0 = wr_cnt; clr0 = clr_cnt;
    issue(32'h0101_0001);
    repeat (6) tick();
    check("early_busy_req_len", 32'(clr_cnt - clr0), 32'd1);
    phf_clear_busy = 1'b0;
    wait_rsp("early_busy", 10);
    repeat (4) tick();
    check("early_busy_rsp", last_rsp, 32'h0101_0000);

    // Reset in the middle of CLR_BUSY aborts the command
    wr0 = wr_cnt;
    issue(32'h0101_0001);
    wait_clear_req("abort", 10, lat);
    phf_clear_busy = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    phf_clear_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    run_simple("after_abort", 32'h0201_005A, 32'h0201_0000, 0);
    check("after_abort_tap", 32'(tap_ctl), 32'h0000_005A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fcr.md
FCR -- requirements
Module: fcr

Interface
REQ-001 The parameter list SHALL be exactly as follows:
- N_TAP_CTL_SIZE, default 8: tap_ctl width, taken from the `N_TAP_CTL_SIZE define in cmd_defs.vh.
- C_TARGET_PHF = 8'h01, C_TARGET_TAP = 8'h02: target codes.
- C_PHF_CLEAR = 8'h01, C_PHF_GET_STATUS = 8'h02, C_TAP_SET = 8'h01: command codes.
- The cmd_defs.vh defines SHALL carry the same values.

REQ-002 The port list SHALL be exactly as follows:
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_data  in  32  command word {target[31:24], opcode[23:16], payload[15:0]}.
- cmd_waitreq  in  1  high = command FIFO empty.
- cmd_rdreq  out  1  command FIFO read strobe.
- rsp_data  out  32  response word {target, opcode, result[15:0]}.
- rsp_wrreq  out  1  response FIFO write strobe.
- rsp_waitreq  in  1  high = response FIFO full.
- tap_ctl  out  N_TAP_CTL_SIZE  registered TAP control word.
- phf_clear_busy  in  1  high while the PHF clear executes.
- phf_status  in  1  PHF status bit.
- phf_rsp_rdy  out  1  one-cycle pulse when a PHF-target response is written.
- phf_clear_req  out  1  PHF clear request.

Function
REQ-003 The controller SHALL be a single FSM with states IDLE, READ, LATCH, EXEC, CLR_REQ, CLR_BUSY, RESP.
REQ-004 In IDLE, cmd_waitreq sampled low SHALL move the FSM to READ, with cmd_rdreq high for exactly that one cycle.
REQ-005 In LATCH, the first edge after the READ cycle, cmd_data SHALL be captured into an internal command register (FIFO read latency one cycle).
REQ-006 In EXEC, the captured word SHALL be decoded, and every command SHALL produce exactly one response word:
- PHF/C_PHF_GET_STATUS: result = {15'b0, phf_status sampled in EXEC}; go to RESP.
- PHF/C_PHF_CLEAR: go to CLR_REQ.
- TAP/C_TAP_SET: tap_ctl <= payload[N_TAP_CTL_SIZE-1:0]; result = 16'h0000; go to RESP.
- Known target with unknown opcode: result = 16'hFFFF; go to RESP.
- Unknown target: result = 16'hFFFE; go to RESP.
REQ-007 In CLR_REQ, phf_clear_req SHALL be driven high, and SHALL be high no later than 3 cycles after the LATCH edge.
REQ-008 phf_clear_req SHALL stay high until phf_clear_busy is sampled high, then drop on the next edge as the FSM enters CLR_BUSY.
REQ-009 In CLR_BUSY, phf_clear_busy sampled low SHALL set result 16'h0000 and move the FSM to RESP.
REQ-010 A 256-cycle counter SHALL run over the combined CLR_REQ and CLR_BUSY time; on expiry, phf_clear_req SHALL drop, result SHALL be 16'hFFFD, and the FSM SHALL go to RESP.
REQ-011 In RESP, rsp_data SHALL be {target, opcode, result} and SHALL remain stable while in RESP.
REQ-012 In RESP with rsp_waitreq low, rsp_wrreq SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-013 In RESP with rsp_waitreq high, rsp_wrreq SHALL stay low and the FSM SHALL wait in RESP.
REQ-014 phf_rsp_rdy SHALL equal rsp_wrreq when the response target is C_TARGET_PHF, and SHALL be low otherwise.
REQ-015 The block SHALL handle only one command at a time; cmd_waitreq SHALL be ignored outside IDLE.
REQ-016 If phf_clear_busy is already high on entry to CLR_REQ, the FSM SHALL proceed directly to CLR_BUSY on the next edge.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 While rst_n is low, the FSM SHALL be in IDLE and outputs SHALL be: cmd_rdreq 0, rsp_wrreq 0, rsp_data 0, tap_ctl 0, phf_clear_req 0, phf_rsp_rdy 0.
REQ-019 Reset asserted mid-command SHALL abort the command; no response SHALL be written for it.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- PHF clear: cmd_waitreq low one cycle, cmd_data 32'h0101_0001, busy raised when clear_req seen, busy dropped 5 cycles later -> one cmd_rdreq pulse; phf_clear_req high, then low after busy; single rsp_wrreq with rsp_data 32'h0101_0000 and phf_rsp_rdy pulse.
- Bad PHF opcode: cmd_data 32'h01AA_0001 -> no phf_clear_req; rsp_data 32'h01AA_FFFF.
- Get status: cmd_data 32'h0102_0001, phf_status 1 -> rsp_data 32'h0102_0001; with phf_status 0 -> 32'h0102_0000.
- TAP set: cmd_data 32'h0201_00A5 -> tap_ctl 8'hA5; rsp_data 32'h0201_0000; phf_rsp_rdy stays 0.
- Backpressure and timeout: rsp_waitreq high 10 cycles during RESP -> rsp_wrreq waits, exactly one write after release; separately, clear with busy never raised -> rsp_data 32'h0101_FFFD after 256 cycles.
- Reset during CLR_BUSY -> all outputs 0, no response, next command processed normally.
